// File: rtl/crc_check.sv
// -----------------------------------------------------------------------------
// crc_check
//
// Purpose:
//   Downstream companion of crc_gen. It compares each frame's computed CRC
//   (crc_gen crc_out / crc_out_vld) against the expected CRC delivered by the
//   framer side-channel, one expected value per frame. Expected CRCs arrive
//   ahead of the computed ones (crc_gen pipeline latency is PIPE_LVL+1 cycles),
//   so they are buffered in an in-order FIFO. Each judged frame produces a
//   registered pass/fail verdict and bumps one of two saturating counters.
//
// Parameters:
//   CRC_WIDTH   width of CRC values (must match crc_gen CRC_WIDTH)
//   FIFO_DEPTH  expected-CRC FIFO entries; power of 2, >= 2, >= PIPE_LVL+2
//   CNT_WIDTH   width of the good/bad frame counters
//
// Ports:
//   clk         clock
//   rst         asynchronous, active-high reset
//   exp_crc     expected CRC of the next frame, in frame order
//   exp_vld     exp_crc valid; accepted when exp_vld & exp_rdy
//   exp_rdy     FIFO can accept an entry (registered, = !full)
//   crc_in      computed CRC from crc_gen
//   crc_in_vld  one-cycle strobe per frame from crc_gen
//   clr_cnt     synchronous clear of good_cnt/bad_cnt
//   res_vld     one-cycle verdict strobe
//   res_pass    verdict: 1 = computed CRC equals expected CRC
//   res_crc     computed CRC of the judged frame
//   res_exp     expected CRC of the judged frame
//   good_cnt    passed frames, saturating
//   bad_cnt     failed frames, saturating
//   err_ovf     sticky: exp_vld while FIFO full (entry dropped)
//   err_udf     sticky: crc_in_vld with no expected CRC available
//
// Optional feature (macro CRC_CHECK_FIRST_FAIL_EN):
//   Adds ff_vld / ff_crc / ff_exp / ff_idx, a capture of the first failing
//   verdict (computed CRC, expected CRC, frame index = good_cnt+bad_cnt before
//   the update). Rearmed by rst or clr_cnt. Without the macro these ports and
//   registers do not exist and all other behaviour is identical.
// -----------------------------------------------------------------------------
module crc_check #(
  parameter int CRC_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CRC_WIDTH-1:0] exp_crc,
  input  logic                 exp_vld,
  output logic                 exp_rdy,
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic                 crc_in_vld,
  input  logic                 clr_cnt,
  output logic                 res_vld,
  output logic                 res_pass,
  output logic [CRC_WIDTH-1:0] res_crc,
  output logic [CRC_WIDTH-1:0] res_exp,
  output logic [CNT_WIDTH-1:0] good_cnt,
  output logic [CNT_WIDTH-1:0] bad_cnt,
  output logic                 err_ovf,
  output logic                 err_udf
`ifdef CRC_CHECK_FIRST_FAIL_EN
  ,
  output logic                 ff_vld,
  output logic [CRC_WIDTH-1:0] ff_crc,
  output logic [CRC_WIDTH-1:0] ff_exp,
  output logic [CNT_WIDTH-1:0] ff_idx
`endif
);

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the index bits match.
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [AW:0]          PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CRC_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [AW:0]          wr_ptr_nxt;
  logic [AW:0]          rd_ptr_nxt;

  logic                 empty;
  logic                 full;
  logic                 full_nxt;
  logic                 push;
  logic                 pop;
  logic                 bypass;
  logic                 verdict;
  logic                 ovf;
  logic                 udf;
  logic                 pass;
  logic [CRC_WIDTH-1:0] exp_sel;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // An expected CRC arriving together with the computed one on an empty
    // FIFO is judged directly instead of round-tripping through the FIFO.
    bypass  = crc_in_vld & empty & exp_vld;
    pop     = crc_in_vld & ~empty;
    // exp_rdy is only low when full (or for the first cycle out of reset), so
    // a pop in a full cycle still refuses the push; the slot opens next cycle.
    push    = exp_vld & exp_rdy & ~bypass;
    ovf     = exp_vld & full;
    udf     = crc_in_vld & empty & ~exp_vld;
    verdict = pop | bypass;

    exp_sel = bypass ? exp_crc : mem[rd_ptr[AW-1:0]];
    pass    = (crc_in == exp_sel);

    wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
    rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;
    full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                 (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; only the pointers do. Stale entries
  // are unreachable once the pointers are equal, and leaving the array out of
  // the reset lets it map onto plain registers/RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= exp_crc;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      exp_rdy <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      // Registered from next-state occupancy, so it never depends on the
      // current-cycle inputs; stays low for the first cycle after release.
      exp_rdy <= ~full_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Verdict register: result fields hold until the next verdict
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld  <= 1'b0;
      res_pass <= 1'b0;
      res_crc  <= '0;
      res_exp  <= '0;
    end else begin
      res_vld <= verdict;
      if (verdict) begin
        res_pass <= pass;
        res_crc  <= crc_in;
        res_exp  <= exp_sel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating frame counters; clr_cnt beats a same-cycle increment
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (clr_cnt) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (verdict) begin
      if (pass && (good_cnt != CNT_MAX)) begin
        good_cnt <= good_cnt + CNT_ONE;
      end
      if (!pass && (bad_cnt != CNT_MAX)) begin
        bad_cnt <= bad_cnt + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags, cleared only by rst
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (ovf) begin
        err_ovf <= 1'b1;
      end
      if (udf) begin
        err_udf <= 1'b1;
      end
    end
  end

`ifdef CRC_CHECK_FIRST_FAIL_EN
  // ---------------------------------------------------------------------------
  // First-failure capture. The frame index is the count of frames judged
  // since the last clear, taken before this frame is counted (it wraps, it
  // does not saturate).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_vld <= 1'b0;
      ff_crc <= '0;
      ff_exp <= '0;
      ff_idx <= '0;
    end else if (clr_cnt) begin
      ff_vld <= 1'b0;
      ff_crc <= '0;
      ff_exp <= '0;
      ff_idx <= '0;
    end else if (verdict && !pass && !ff_vld) begin
      ff_vld <= 1'b1;
      ff_crc <= crc_in;
      ff_exp <= exp_sel;
      ff_idx <= good_cnt + bad_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_crc_check.sv
// -----------------------------------------------------------------------------
// tb_crc_check
//
// Self-checking bench for crc_check. A queue-based model of the expected-CRC
// buffer and the verdict/counter rules tracks what every output must be; one
// compare process checks all DUT outputs against it every cycle. A directed
// section with hand-computed literal values pins the model, followed by a
// randomized phase with occasional resets. CNT_WIDTH is reduced so counter
// saturation is reachable.
// -----------------------------------------------------------------------------
module tb_crc_check;

  localparam int CRC_W = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 6;
  localparam longint CMAX = (longint'(1) << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CRC_W-1:0] exp_crc = '0;
  logic             exp_vld = 1'b0;
  logic             exp_rdy;
  logic [CRC_W-1:0] crc_in = '0;
  logic             crc_in_vld = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             res_vld;
  logic             res_pass;
  logic [CRC_W-1:0] res_crc;
  logic [CRC_W-1:0] res_exp;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;
  logic             err_ovf;
  logic             err_udf;
`ifdef CRC_CHECK_FIRST_FAIL_EN
  logic             ff_vld;
  logic [CRC_W-1:0] ff_crc;
  logic [CRC_W-1:0] ff_exp;
  logic [CNT_W-1:0] ff_idx;
`endif

  crc_check #(
    .CRC_WIDTH (CRC_W),
    .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .exp_crc   (exp_crc),
    .exp_vld   (exp_vld),
    .exp_rdy   (exp_rdy),
    .crc_in    (crc_in),
    .crc_in_vld(crc_in_vld),
    .clr_cnt   (clr_cnt),
    .res_vld   (res_vld),
    .res_pass  (res_pass),
    .res_crc   (res_crc),
    .res_exp   (res_exp),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf)
`ifdef CRC_CHECK_FIRST_FAIL_EN
    ,
    .ff_vld    (ff_vld),
    .ff_crc    (ff_crc),
    .ff_exp    (ff_exp),
    .ff_idx    (ff_idx)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the buffer is a queue, counters are plain integers.
  // ---------------------------------------------------------------------------
  logic [CRC_W-1:0] m_q[$];
  bit               m_rdy  = 1'b0;
  bit               m_vld  = 1'b0;
  bit               m_pass = 1'b0;
  logic [CRC_W-1:0] m_crc  = '0;
  logic [CRC_W-1:0] m_exp  = '0;
  longint           m_good = 0;
  longint           m_bad  = 0;
  bit               m_ovf  = 1'b0;
  bit               m_udf  = 1'b0;
  bit               m_ffv  = 1'b0;
  logic [CRC_W-1:0] m_ffc  = '0;
  logic [CRC_W-1:0] m_ffe  = '0;
  longint           m_ffi  = 0;

  initial forever begin
    bit               was_empty;
    bit               judged;
    bit               ok;
    logic [CRC_W-1:0] expv;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_q.delete();
      m_rdy = 0; m_vld = 0; m_pass = 0; m_crc = '0; m_exp = '0;
      m_good = 0; m_bad = 0; m_ovf = 0; m_udf = 0;
      m_ffv = 0; m_ffc = '0; m_ffe = '0; m_ffi = 0;
    end else begin
      was_empty = (m_q.size() == 0);
      judged    = 1'b0;
      expv      = '0;
      if (exp_vld && m_q.size() == DEPTH) m_ovf = 1'b1;
      if (crc_in_vld) begin
        if (!was_empty) begin
          expv = m_q.pop_front();
          judged = 1'b1;
        end else if (exp_vld) begin
          expv = exp_crc;
          judged = 1'b1;
        end else begin
          m_udf = 1'b1;
        end
      end
      if (exp_vld && m_rdy && !(crc_in_vld && was_empty)) m_q.push_back(exp_crc);
      ok    = (crc_in == expv);
      m_vld = judged;
      if (judged) begin
        m_pass = ok;
        m_crc  = crc_in;
        m_exp  = expv;
      end
      if (clr_cnt) begin
        m_good = 0; m_bad = 0;
        m_ffv = 0; m_ffc = '0; m_ffe = '0; m_ffi = 0;
      end else if (judged) begin
        if (!ok && !m_ffv) begin
          m_ffv = 1'b1; m_ffc = crc_in; m_ffe = expv;
          m_ffi = (m_good + m_bad) % (CMAX + 1);
        end
        if (ok) m_good = (m_good == CMAX) ? CMAX : m_good + 1;
        else    m_bad  = (m_bad  == CMAX) ? CMAX : m_bad + 1;
      end
      m_rdy = (m_q.size() != DEPTH);
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every cycle, 2 time units after the active edge.
  // ---------------------------------------------------------------------------
  initial forever begin
    @(posedge clk);
    #2;
    if (cmp_en) begin
      check("exp_rdy",  exp_rdy,  m_rdy);
      check("res_vld",  res_vld,  m_vld);
      check("res_pass", res_pass, m_pass);
      check("res_crc",  res_crc,  m_crc);
      check("res_exp",  res_exp,  m_exp);
      check("good_cnt", good_cnt, m_good);
      check("bad_cnt",  bad_cnt,  m_bad);
      check("err_ovf",  err_ovf,  m_ovf);
      check("err_udf",  err_udf,  m_udf);
`ifdef CRC_CHECK_FIRST_FAIL_EN
      check("ff_vld",   ff_vld,   m_ffv);
      check("ff_crc",   ff_crc,   m_ffc);
      check("ff_exp",   ff_exp,   m_ffe);
      check("ff_idx",   ff_idx,   m_ffi);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input bit ev, input logic [CRC_W-1:0] ec,
                       input bit cv, input logic [CRC_W-1:0] cc, input bit clr);
    @(negedge clk);
    exp_vld    = ev;
    exp_crc    = ec;
    crc_in_vld = cv;
    crc_in     = cc;
    clr_cnt    = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [CRC_W-1:0] fill_val;

  initial begin
    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_vld", res_vld, 0);
    check("rst_exp_rdy", exp_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rel_exp_rdy_low", exp_rdy, 0);
    tick();
    check("rel_exp_rdy_high", exp_rdy, 1);

    // Two matching frames through the FIFO.
    drive(1, 16'h1234, 0, 0, 0); tick();
    drive(1, 16'hBEEF, 0, 0, 0); tick();
    drive(0, 0, 1, 16'h1234, 0); tick();
    check("t1_vld0",  res_vld,  1);
    check("t1_pass0", res_pass, 1);
    check("t1_crc0",  res_crc,  16'h1234);
    drive(0, 0, 1, 16'hBEEF, 0); tick();
    check("t1_pass1", res_pass, 1);
    check("t1_exp1",  res_exp,  16'hBEEF);
    check("t1_good",  good_cnt, 2);
    check("t1_bad",   bad_cnt,  0);
    drive(0, 0, 0, 0, 0); tick();
    check("t1_vld_idle",  res_vld,  0);
    check("t1_pass_hold", res_pass, 1);

    // One mismatching frame after a counter clear.
    drive(0, 0, 0, 0, 1); tick();
    check("t2_clr_good", good_cnt, 0);
    drive(1, 16'h00FF, 0, 0, 0); tick();
    drive(0, 0, 1, 16'h00FE, 0); tick();
    check("t2_vld",  res_vld,  1);
    check("t2_pass", res_pass, 0);
    check("t2_crc",  res_crc,  16'h00FE);
    check("t2_exp",  res_exp,  16'h00FF);
    check("t2_bad",  bad_cnt,  1);
`ifdef CRC_CHECK_FIRST_FAIL_EN
    check("t2_ff_vld", ff_vld, 1);
    check("t2_ff_idx", ff_idx, 0);
`endif

    // Fill, overflow, then drain in order.
    for (int k = 0; k < DEPTH; k++) begin
      fill_val = 16'(16'h1111 * (k + 1));
      drive(1, fill_val, 0, 0, 0); tick();
    end
    check("t3_rdy_full", exp_rdy, 0);
    drive(1, 16'h5555, 0, 0, 0); tick();
    check("t3_ovf",      err_ovf, 1);
    check("t3_rdy_ovf",  exp_rdy, 0);
    for (int k = 0; k < DEPTH; k++) begin
      fill_val = 16'(16'h1111 * (k + 1));
      drive(0, 0, 1, fill_val, 0); tick();
      check("t3_drain_pass", res_pass, 1);
      check("t3_drain_exp",  res_exp,  fill_val);
    end

    // Bypass on empty FIFO, then underflow.
    drive(1, 16'hA5A5, 1, 16'hA5A5, 0); tick();
    check("t4_byp_vld",  res_vld,  1);
    check("t4_byp_pass", res_pass, 1);
    check("t4_byp_rdy",  exp_rdy,  1);
    drive(0, 0, 1, 16'h7777, 0); tick();
    check("t4_udf",      err_udf, 1);
    check("t4_udf_vld",  res_vld, 0);
    check("t4_udf_crc",  res_crc, 16'hA5A5);
    check("t4_udf_bad",  bad_cnt, 1);

    // Saturation of good_cnt, then clear against a same-cycle verdict.
    for (int k = 0; k < 70; k++) begin
      drive(1, 16'(k), 1, 16'(k), 0); tick();
    end
    check("t5_sat", good_cnt, CMAX);
    drive(1, 16'h0007, 1, 16'h0007, 1); tick();
    check("t5_clr_vld",  res_vld,  1);
    check("t5_clr_good", good_cnt, 0);
    check("t5_clr_bad",  bad_cnt,  0);

    // Asynchronous reset with entries queued.
    drive(1, 16'h4242, 1, 16'h4242, 0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'(16'hC000 + k), 0, 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_good0", good_cnt, 0);
    check("t6_ovf0",  err_ovf,  0);
    check("t6_udf0",  err_udf,  0);
    check("t6_rdy0",  exp_rdy,  0);
    check("t6_pass0", res_pass, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6_rdy1", exp_rdy, 1);
    drive(0, 0, 1, 16'hC000, 0); tick();
    check("t6_empty_udf", err_udf, 1);
    check("t6_empty_vld", res_vld, 0);

    // Randomized phase with occasional resets.
    begin
      bit post_rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (post_rst) begin
          rst = 1'b0;
          exp_vld = 0; crc_in_vld = 0; clr_cnt = 0;
          post_rst = 1'b0;
          continue;
        end
        if (i % 700 == 699) begin
          rst = 1'b1;
          exp_vld = 0; crc_in_vld = 0; clr_cnt = 0;
          post_rst = 1'b1;
          continue;
        end
        exp_vld    = ($urandom_range(99) < 50);
        exp_crc    = 16'($urandom);
        crc_in_vld = ($urandom_range(99) < 45);
        clr_cnt    = ($urandom_range(99) < 2);
        if (m_q.size() != 0 && $urandom_range(99) < 75)
          crc_in = m_q[0];
        else if (m_q.size() == 0 && exp_vld && $urandom_range(99) < 75)
          crc_in = exp_crc;
        else
          crc_in = 16'($urandom);
      end
    end
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
